binpool2: RTL and testbench
===========================

BINPOOL2 -- requirements
Module: binpool2

Interface
REQ-001 SHALL have parameter CH, default 60: number of binary feature-map channels per frame.
REQ-002 SHALL have parameter DIM, default 8: input map height/width; output map is DIM/2 x DIM/2.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_map_data  input  CH*DIM*DIM  binarized conv map, ascending [0:N-1]; pixel (c,r,k) at bit c*DIM*DIM + r*DIM + k.
REQ-006 i_valid  input  1  i_map_data is valid.
REQ-007 o_ready  output  1  block can accept a frame.
REQ-008 o_pool_data  output  (DIM/2)^2  pooled map of one channel; pixel (r,k) at bit r*(DIM/2)+k.
REQ-009 o_ch  output  $clog2(CH)  channel index of o_pool_data.
REQ-010 o_valid  output  1  o_pool_data/o_ch are valid.
REQ-011 i_ready  input  1  downstream accepts the current channel.
REQ-012 o_last  output  1  asserted with o_valid on the final channel (CH-1).

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
REQ-014 IDLE: o_ready=1, o_valid=0; on i_valid&&o_ready, SHALL register i_map_data, clear channel counter, go to RUN next cycle.
REQ-015 RUN: o_ready=0, o_valid=1; i_valid SHALL be ignored, with no recapture.
REQ-016 o_pool_data pixel (r,k) SHALL be the OR of input pixels (2r,2k), (2r,2k+1), (2r+1,2k), (2r+1,2k+1) of channel o_ch (binary max-pool).
REQ-017 Latency: first o_valid SHALL appear the cycle after frame acceptance.
REQ-018 On o_valid&&i_ready with o_ch<CH-1, counter SHALL increment; with o_ch==CH-1, SHALL return to IDLE.
REQ-019 While o_valid&&!i_ready, o_pool_data, o_ch and o_last SHALL hold stable.
REQ-020 Outputs SHALL depend only on registered state; no combinational path from i_* inputs to o_* outputs.
REQ-021 Full-rate throughput: one frame per CH+1 cycles when i_ready is held high.
REQ-022 CH=1: the first output SHALL carry o_last=1.

Reset
REQ-023 With i_rst_n=0 at a clock edge: state=IDLE, counter=0, o_valid=0, o_last=0, o_ch=0, o_pool_data=0; o_ready=1 from the first cycle after reset release.
REQ-024 Reset during RUN SHALL abort the frame; no further channels are emitted.
REQ-025 The captured map register is not required to be cleared by reset.

Configuration
REQ-026 Macro BINPOOL2_POPCNT_EN: when defined, SHALL add output o_popcnt, width $clog2((DIM/2)^2+1), equal to the count of ones in o_pool_data, aligned with and held alongside it.
REQ-027 When BINPOOL2_POPCNT_EN is undefined, o_popcnt and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 binnet_pkg SHALL hold constants C_CONV2_CH=60, C_CONV2_DIM=8, C_POOL2_DIM=4 and the FSM state enum typedef.
REQ-029 Single sub-module pool2x2_or SHALL be combinational, taking one DIM x DIM channel and producing its (DIM/2)^2 pooled bits; instantiated once and fed by a channel mux.

Verification
REQ-030 All-zero frame, i_ready=1 -> 60 beats, o_pool_data=16'h0000, o_ch 0..59, o_last only on beat 60, o_ready=1 on the cycle after.
REQ-031 Channel 5 with only pixel (7,7)=1 -> o_ch=5 beat has bit 15=1 and all other bits 0; all other channels 0; popcnt=1 when enabled.
REQ-032 i_ready toggled 1,0,0,1 repeatedly -> no beats lost or duplicated; data stable during stalls; 60 beats total.
REQ-033 New i_valid frame presented during RUN -> ignored; outputs continue from the first frame; second frame accepted only after return to IDLE.
REQ-034 i_rst_n=0 at o_ch=30 -> next cycle o_valid=0, o_ready=1; new frame restarts at o_ch=0.
REQ-035 All-ones frame -> every beat 16'hFFFF; o_popcnt=16 when BINPOOL2_POPCNT_EN is defined.

Source files
------------

// File: rtl/binnet_pkg.sv
// Shared constants and types for the binary-network pooling stage.
// Holds the conv2 map geometry, the pooled map size, the pooling FSM
// state type and a width helper used by the pooling blocks.
package binnet_pkg;

    localparam int C_CONV2_CH  = 60;
    localparam int C_CONV2_DIM = 8;
    localparam int C_POOL2_DIM = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index width that never collapses to zero bits (e.g. a single channel).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/binpool2_pool2x2_or.sv
// pool2x2_or: combinational 2x2 binary max-pool of one DIM x DIM channel.
// Input pixel (r,k) sits at bit r*DIM+k; output pixel (r,k) at bit r*(DIM/2)+k.
// On binary data the max of a window is simply the OR of its four pixels.
module pool2x2_or #(
    parameter  int DIM = 8,
    localparam int PD  = DIM / 2
) (
    input  logic [0:DIM*DIM-1] i_chan,
    output logic [PD*PD-1:0]   o_pool
);

    // OR each non-overlapping 2x2 window into one output pixel
    always_comb begin
        o_pool = '0;
        for (int r = 0; r < PD; r++) begin
            for (int k = 0; k < PD; k++) begin
                o_pool[r*PD+k] = i_chan[(2*r)*DIM   + 2*k]
                               | i_chan[(2*r)*DIM   + 2*k + 1]
                               | i_chan[(2*r+1)*DIM + 2*k]
                               | i_chan[(2*r+1)*DIM + 2*k + 1];
            end
        end
    end

endmodule

// File: rtl/binpool2.sv
// binpool2: captures one binarized CH x DIM x DIM conv map, then streams one
// 2x2-OR-pooled channel per beat with valid/ready handshaking.
// Optional feature: define BINPOOL2_POPCNT_EN to add o_popcnt, the number of
// ones in o_pool_data, presented alongside it.
// All outputs are decoded from registered state only (state, channel counter,
// captured map), so there is no combinational path from any input.
module binpool2
    import binnet_pkg::*;
#(
    parameter  int CH   = C_CONV2_CH,
    parameter  int DIM  = C_CONV2_DIM,
    localparam int PD   = DIM / 2,
    localparam int NPIX = CH * DIM * DIM,
    localparam int CH_W = clog2_min1(CH),
    localparam int PC_W = $clog2(PD * PD + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [0:NPIX-1]   i_map_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [PD*PD-1:0]  o_pool_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_valid,
    input  logic              i_ready,
`ifdef BINPOOL2_POPCNT_EN
    output logic [PC_W-1:0]   o_popcnt,
`endif
    output logic              o_last
);

    state_t              r_state;
    state_t              w_next;
    logic [0:NPIX-1]     r_map;
    logic [CH_W-1:0]     r_ch;
    logic                w_accept;
    logic                w_advance;
    logic                w_final;
    logic [0:DIM*DIM-1]  w_chan;
    logic [PD*PD-1:0]    w_pool;

    assign w_final   = (r_ch == CH_W'(CH - 1));
    assign w_accept  = (r_state == ST_IDLE) && i_valid;
    assign w_advance = (r_state == ST_RUN) && i_ready;

    // FSM state register; reset aborts any frame in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: accept a frame in IDLE, leave RUN after the last channel is taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_valid)             w_next = ST_RUN;
            ST_RUN:  if (i_ready && w_final)  w_next = ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    // Channel counter: cleared on frame accept, advances on each taken beat
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ch <= '0;
        end else if (w_accept) begin
            r_ch <= '0;
        end else if (w_advance && !w_final) begin
            r_ch <= r_ch + 1'b1;
        end
    end

    // Frame capture; only loaded in IDLE so frames offered during RUN are dropped
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_map <= i_map_data;
        end
    end

    // Channel mux selecting the current channel's DIM x DIM slice for the pooler
    always_comb begin
        w_chan = '0;
        for (int c = 0; c < CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_chan = r_map[c*DIM*DIM +: DIM*DIM];
            end
        end
    end

    pool2x2_or #(
        .DIM (DIM)
    ) u_pool (
        .i_chan (w_chan),
        .o_pool (w_pool)
    );

    // FSM outputs: data is forced to zero outside RUN since the map is never cleared
    always_comb begin
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_last      = 1'b0;
        o_pool_data = '0;
        case (r_state)
            ST_IDLE: o_ready = 1'b1;
            ST_RUN: begin
                o_valid     = 1'b1;
                o_last      = w_final;
                o_pool_data = w_pool;
            end
            default: o_ready = 1'b0;
        endcase
    end

    assign o_ch = r_ch;

`ifdef BINPOOL2_POPCNT_EN
    // Population count of the presented pooled channel
    always_comb begin
        o_popcnt = '0;
        for (int i = 0; i < PD * PD; i++) begin
            o_popcnt = o_popcnt + PC_W'(o_pool_data[i]);
        end
    end
`endif

endmodule

// File: tb/tb_binpool2.sv
// Testbench for binpool2: directed frames plus sparse random frames, checked
// beat by beat against a window-maximum reference computed from the frame.
// Define BINPOOL2_POPCNT_EN to also check o_popcnt.
module tb_binpool2;
    import binnet_pkg::*;

    localparam int CH  = C_CONV2_CH;
    localparam int DIM = C_CONV2_DIM;
    localparam int PD  = C_POOL2_DIM;
    localparam int N   = CH * DIM * DIM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [0:N-1]  map;
    logic          vin;
    logic          rdy_in;
    logic          o_ready;
    logic [15:0]   o_pool_data;
    logic [5:0]    o_ch;
    logic          o_valid;
    logic          o_last;
`ifdef BINPOOL2_POPCNT_EN
    logic [4:0]    o_popcnt;
`endif

    // Single-channel 2x2 instance for the one-channel boundary
    logic [0:3]    map1;
    logic          vin1;
    logic          rdy1;
    logic          o_ready1;
    logic [0:0]    o_pool1;
    logic [0:0]    o_ch1;
    logic          o_valid1;
    logic          o_last1;
`ifdef BINPOOL2_POPCNT_EN
    logic [0:0]    o_popcnt1;
`endif

    int total = 0;
    int bad   = 0;

    binpool2 #(.CH(CH), .DIM(DIM)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_map_data  (map),
        .i_valid     (vin),
        .o_ready     (o_ready),
        .o_pool_data (o_pool_data),
        .o_ch        (o_ch),
        .o_valid     (o_valid),
        .i_ready     (rdy_in),
`ifdef BINPOOL2_POPCNT_EN
        .o_popcnt    (o_popcnt),
`endif
        .o_last      (o_last)
    );

    binpool2 #(.CH(1), .DIM(2)) u_dut1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_map_data  (map1),
        .i_valid     (vin1),
        .o_ready     (o_ready1),
        .o_pool_data (o_pool1),
        .o_ch        (o_ch1),
        .o_valid     (o_valid1),
        .i_ready     (rdy1),
`ifdef BINPOOL2_POPCNT_EN
        .o_popcnt    (o_popcnt1),
`endif
        .o_last      (o_last1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each pooled pixel is the maximum over its 2x2 input window
    function automatic logic [15:0] pool_ref(input logic [0:N-1] f, input int c);
        logic [15:0] p;
        p = '0;
        for (int r = 0; r < PD; r++)
            for (int k = 0; k < PD; k++)
                for (int dr = 0; dr < 2; dr++)
                    for (int dk = 0; dk < 2; dk++)
                        if (f[c*DIM*DIM + (2*r+dr)*DIM + (2*k+dk)] == 1'b1)
                            p[r*PD+k] = 1'b1;
        return p;
    endfunction

    function automatic logic [0:N-1] rand_frame();
        logic [0:N-1] f;
        for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 15) == 0);
        return f;
    endfunction

    // mode 0: i_ready high; 1: i_ready 1,0,0,1 repeating; 2: random i_ready;
    // 3: i_ready high while frame f2 is offered throughout the run.
    // abort_at >= 0 pulls reset when that channel is on the output.
    task automatic run_frame(input logic [0:N-1] f, input int mode,
                             input logic [0:N-1] f2, input int abort_at);
        int b;
        int cyc;
        logic rdy;
        logic [15:0] exp_p;
        b   = 0;
        cyc = 0;
        while (o_ready !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("idle_ready", 32'(o_ready), 32'd1);
        chk("idle_valid", 32'(o_valid), 32'd0);
        map = f;
        vin = 1'b1;
        step();
        if (mode == 3) map = f2;
        else vin = 1'b0;
        cyc = 0;
        while (b < CH && cyc < CH * 5) begin
            exp_p = pool_ref(f, b);
            chk("valid", 32'(o_valid), 32'd1);
            chk("ready_low", 32'(o_ready), 32'd0);
            chk("ch", 32'(o_ch), 32'(b));
            chk("data", 32'(o_pool_data), 32'(exp_p));
            chk("last", 32'(o_last), 32'(b == CH - 1));
`ifdef BINPOOL2_POPCNT_EN
            chk("popcnt", 32'(o_popcnt), 32'($countones(exp_p)));
`endif
            if (b == abort_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                chk("abort_valid", 32'(o_valid), 32'd0);
                chk("abort_ready", 32'(o_ready), 32'd1);
                chk("abort_ch", 32'(o_ch), 32'd0);
                chk("abort_data", 32'(o_pool_data), 32'd0);
                chk("abort_last", 32'(o_last), 32'd0);
                step();
                chk("abort_quiet", 32'(o_valid), 32'd0);
                return;
            end
            case (mode)
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            rdy_in = rdy;
            step();
            cyc++;
            if (rdy) b++;
        end
        chk("beats", 32'(b), 32'(CH));
        chk("done_valid", 32'(o_valid), 32'd0);
        chk("done_ready", 32'(o_ready), 32'd1);
        rdy_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:N-1] fa;
        logic [0:N-1] fb;
        rst_n  = 1'b0;
        vin    = 1'b0;
        rdy_in = 1'b0;
        map    = '0;
        map1   = '0;
        vin1   = 1'b0;
        rdy1   = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_ch", 32'(o_ch), 32'd0);
        chk("rst_data", 32'(o_pool_data), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(o_ready), 32'd1);

        // all-zero frame
        fa = '0;
        run_frame(fa, 0, fa, -1);

        // channel 5, single pixel (7,7)
        fa = '0;
        fa[5*DIM*DIM + 7*DIM + 7] = 1'b1;
        run_frame(fa, 0, fa, -1);

        // stalls with i_ready pattern 1,0,0,1
        fa = rand_frame();
        run_frame(fa, 1, fa, -1);

        // frame offered during RUN is ignored, then accepted afterwards
        fa = rand_frame();
        fb = rand_frame();
        run_frame(fa, 3, fb, -1);
        run_frame(fb, 0, fb, -1);

        // reset at channel 30, then a fresh frame with random stalls
        fa = rand_frame();
        run_frame(fa, 0, fa, 30);
        fa = rand_frame();
        run_frame(fa, 2, fa, -1);

        // all-ones frame
        fa = '1;
        run_frame(fa, 2, fa, -1);

        // single-channel instance: first beat is also the last
        map1 = 4'b0100;
        vin1 = 1'b1;
        step();
        vin1 = 1'b0;
        chk("ch1_valid", 32'(o_valid1), 32'd1);
        chk("ch1_last", 32'(o_last1), 32'd1);
        chk("ch1_data", 32'(o_pool1), 32'd1);
        chk("ch1_ch", 32'(o_ch1), 32'd0);
        step();
        chk("ch1_hold", 32'(o_valid1), 32'd1);
`ifdef BINPOOL2_POPCNT_EN
        chk("ch1_popcnt", 32'(o_popcnt1), 32'd1);
`endif
        rdy1 = 1'b1;
        step();
        chk("ch1_done_valid", 32'(o_valid1), 32'd0);
        chk("ch1_done_ready", 32'(o_ready1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
